// File: rtl/vga_sync_gen.sv
// 640x480 VGA raster timing generator: free-running position counters with
// registered active-low syncs, visible-region flag, pixel coordinates and frame strobe.
module vga_sync_gen #(
    parameter int unsigned HPIXELS = 800,
    parameter int unsigned VLINES  = 521,
    parameter int unsigned HPULSE  = 96,
    parameter int unsigned VPULSE  = 2,
    parameter int unsigned HBP     = 144,
    parameter int unsigned HFP     = 784,
    parameter int unsigned VBP     = 31,
    parameter int unsigned VFP     = 511
) (
    input  logic       dclk,
    input  logic       clr,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam logic [9:0] HLast   = 10'(HPIXELS - 1);
    localparam logic [9:0] VLast   = 10'(VLINES - 1);
    localparam logic [9:0] HPulseW = 10'(HPULSE);
    localparam logic [9:0] VPulseW = 10'(VPULSE);
    localparam logic [9:0] HStart  = 10'(HBP);
    localparam logic [9:0] HEnd    = 10'(HFP);
    localparam logic [9:0] VStart  = 10'(VBP);
    localparam logic [9:0] VEnd    = 10'(VFP);

    logic [9:0] hc;
    logic [9:0] vc;

    logic       hsync_d;
    logic       vsync_d;
    logic       active_d;
    logic [9:0] x_d;
    logic [9:0] y_d;
    logic       frame_start_d;

    always_ff @(posedge dclk) begin
        if (clr) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HLast) begin
            hc <= '0;
            vc <= (vc == VLast) ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    // Decode the current count; the registers below add one clock of latency.
    always_comb begin
        hsync_d       = ~(hc < HPulseW);
        vsync_d       = ~(vc < VPulseW);
        active_d      = (hc >= HStart) && (hc < HEnd) && (vc >= VStart) && (vc < VEnd);
        x_d           = '0;
        y_d           = '0;
        if (active_d) begin
            x_d = hc - HStart;
            y_d = vc - VStart;
        end
        frame_start_d = (hc == '0) && (vc == '0);
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            active      <= active_d;
            x           <= x_d;
            y           <= y_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing and shrunken-timing instances checked each
// cycle against a position model derived from the count of edges since reset.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } out_t;

    localparam out_t RstOut = '{hs: 1'b1, vs: 1'b1, act: 1'b0, x: 10'd0, y: 10'd0, fs: 1'b0};

    logic       dclk = 1'b0;
    logic       clr_a = 1'b1;
    logic       clr_s = 1'b1;
    logic       hs_a, vs_a, act_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       hs_s, vs_s, act_s, fs_s;
    logic [9:0] x_s, y_s;

    int total = 0;
    int bad = 0;
    bit small_done = 1'b0;

    always #20 dclk = ~dclk;

    vga_sync_gen dut (
        .dclk(dclk), .clr(clr_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
        .x(x_a), .y(y_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .HPIXELS(10), .VLINES(6), .HPULSE(2), .VPULSE(1),
        .HBP(3), .HFP(9), .VBP(2), .VFP(5)
    ) dut_s (
        .dclk(dclk), .clr(clr_s), .hsync(hs_s), .vsync(vs_s), .active(act_s),
        .x(x_s), .y(y_s), .frame_start(fs_s)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raster position is simply the number of unreset edges modulo line/frame length.
    function automatic out_t model(input int n, input int hp, input int vl, input int hpul,
                                   input int vpul, input int hbp, input int hfp,
                                   input int vbp, input int vfp);
        out_t m;
        int h;
        int v;
        h     = n % hp;
        v     = (n / hp) % vl;
        m.hs  = !(h < hpul);
        m.vs  = !(v < vpul);
        m.act = (h >= hbp) && (h < hfp) && (v >= vbp) && (v < vfp);
        m.x   = m.act ? 10'(h - hbp) : 10'd0;
        m.y   = m.act ? 10'(v - vbp) : 10'd0;
        m.fs  = (h == 0) && (v == 0);
        return m;
    endfunction

    task automatic cmp(input string tag, input out_t got, input out_t exp);
        check({tag, ".hsync"}, int'(got.hs), int'(exp.hs));
        check({tag, ".vsync"}, int'(got.vs), int'(exp.vs));
        check({tag, ".active"}, int'(got.act), int'(exp.act));
        check({tag, ".x"}, int'(got.x), int'(exp.x));
        check({tag, ".y"}, int'(got.y), int'(exp.y));
        check({tag, ".frame_start"}, int'(got.fs), int'(exp.fs));
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        int   na = 0;
        int   ns = 0;
        logic ca, cs;
        out_t ea, es;
        forever begin
            @(posedge dclk);
            ca = clr_a;
            cs = clr_s;
            #1;
            ea = ca ? RstOut : model(na, 800, 521, 96, 2, 144, 784, 31, 511);
            es = cs ? RstOut : model(ns, 10, 6, 2, 1, 3, 9, 2, 5);
            na = ca ? 0 : na + 1;
            ns = cs ? 0 : ns + 1;
            cmp("dflt", '{hs: hs_a, vs: vs_a, act: act_a, x: x_a, y: y_a, fs: fs_a}, ea);
            cmp("small", '{hs: hs_s, vs: vs_s, act: act_s, x: x_s, y: y_s, fs: fs_s}, es);
            check("dflt.hc_probe", int'(dut.hc), na % 800);
            check("dflt.vc_probe", int'(dut.vc), (na / 800) % 521);
            check("small.hc_probe", int'(dut_s.hc), ns % 10);
            check("small.vc_probe", int'(dut_s.vc), (ns / 10) % 6);
        end
    end

    // Shrunken timing: wrap-around, per-frame counts, then random resets.
    initial begin
        int fs_cnt = 0;
        int last_fs = 0;
        int act_f0 = 0;
        int vs_f0 = 0;
        int xmax = 0;
        int ymax = 0;
        repeat (3) @(negedge dclk);
        clr_s = 1'b0;
        for (int e = 1; e <= 150; e++) begin
            @(posedge dclk);
            #1;
            if (fs_s) begin
                if (fs_cnt > 0) check("small.fs_spacing", e - last_fs, 60);
                fs_cnt++;
                last_fs = e;
            end
            if (e <= 60 && act_s) act_f0++;
            if (e <= 60 && !vs_s) vs_f0++;
            if (act_s && int'(x_s) > xmax) xmax = int'(x_s);
            if (act_s && int'(y_s) > ymax) ymax = int'(y_s);
        end
        check("small.fs_pulses", fs_cnt, 3);
        check("small.active_per_frame", act_f0, 18);
        check("small.vsync_low", vs_f0, 10);
        check("small.x_max", xmax, 5);
        check("small.y_max", ymax, 2);
        for (int i = 0; i < 2000; i++) begin
            @(negedge dclk);
            clr_s = ($urandom_range(0, 39) == 0);
        end
        @(negedge dclk);
        clr_s = 1'b0;
        small_done = 1'b1;
    end

    // Default timing: reset hold/release, line and early-frame timing, mid-line reset.
    initial begin
        int hs_low0 = 0;
        int hs_high0 = 0;
        int vs_low = 0;
        int act_cnt = 0;
        int fs_cnt = 0;
        repeat (2) @(negedge dclk);
        clr_a = 1'b0;
        repeat (1000) @(negedge dclk);
        clr_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge dclk);
            #1;
            check("hold.hsync", int'(hs_a), 1);
            check("hold.vsync", int'(vs_a), 1);
            check("hold.active", int'(act_a), 0);
            check("hold.fs", int'(fs_a), 0);
        end
        @(negedge dclk);
        clr_a = 1'b0;
        for (int e = 1; e <= 36 * 800; e++) begin
            @(posedge dclk);
            #1;
            if (e == 1) begin
                check("rel.hsync", int'(hs_a), 0);
                check("rel.vsync", int'(vs_a), 0);
                check("rel.fs", int'(fs_a), 1);
                check("rel.active", int'(act_a), 0);
            end
            if (e <= 800) begin
                if (!hs_a) hs_low0++;
                else hs_high0++;
            end
            if (!vs_a) vs_low++;
            if (act_a) act_cnt++;
            if (fs_a) fs_cnt++;
            if (e == 24944) check("pre_first.active", int'(act_a), 0);
            if (e == 24945) begin
                check("first.active", int'(act_a), 1);
                check("first.x", int'(x_a), 0);
                check("first.y", int'(y_a), 0);
            end
            if (e == 25584) begin
                check("last_in_line.active", int'(act_a), 1);
                check("last_in_line.x", int'(x_a), 639);
            end
            if (e == 25585) check("after_line.active", int'(act_a), 0);
            if (e == 25745) check("row1.y", int'(y_a), 1);
        end
        check("line.hsync_low", hs_low0, 96);
        check("line.hsync_high", hs_high0, 704);
        check("frame.vsync_low", vs_low, 1600);
        check("lines31_35.active", act_cnt, 3200);
        check("frame.fs_count", fs_cnt, 1);
        // Counter now holds hc=0, vc=36; advance to hc=400 and reset for one edge.
        repeat (400) @(negedge dclk);
        clr_a = 1'b1;
        @(posedge dclk);
        #1;
        check("midrst.hsync", int'(hs_a), 1);
        check("midrst.vsync", int'(vs_a), 1);
        check("midrst.active", int'(act_a), 0);
        check("midrst.fs", int'(fs_a), 0);
        @(negedge dclk);
        clr_a = 1'b0;
        @(posedge dclk);
        #1;
        check("postrst.fs", int'(fs_a), 1);
        check("postrst.hsync", int'(hs_a), 0);
        for (int i = 0; i < 5000 && !small_done; i++) @(posedge dclk);
        check("small.completed", int'(small_done), 1);
        repeat (3) @(posedge dclk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
